pdo_parser: RTL and testbench



---
 rtl/pdo_parser_pkg.sv | 20 ++
 rtl/pdo_parser.sv | 79 +++++++
 tb/tb_pdo_parser.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pdo_parser_pkg.sv
// Shared types and sizing helpers for the pdo_parser block.
// Holds word/block widths, the clog2 helper and the IDLE/BUSY state enum.
package pdo_parser_pkg;

  localparam int WORD_W = 32;
  localparam int BLK_W  = 128;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/pdo_parser.sv
// Parallel-to-serial output buffer: captures a 128*KD-bit block, emits it
// as 32-bit words MSW first. Optional macro: PDO_PARSER_ZEROIZE_EN.
module pdo_parser
  import pdo_parser_pkg::*;
#(
  parameter  int KD   = 1,
  localparam int NW_W = clog2(4*KD+1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [BLK_W*KD-1:0]   din,
  input  logic [NW_W-1:0]       nwords,
  input  logic                  ld,
  output logic [WORD_W-1:0]     pdo,
  output logic                  pdo_valid,
  input  logic                  pdo_ready,
  output logic                  pdo_last,
  output logic                  busy,
  output logic                  done
);

  localparam int BW = BLK_W * KD;
  localparam logic [NW_W-1:0] NFULL = NW_W'(4 * KD);
  localparam logic [NW_W-1:0] ONE   = NW_W'(1);

  state_e            state_q;
  logic [BW-1:0]     bfr_q;
  logic [BW-1:0]     bfr_d;
  logic [NW_W-1:0]   cnt_q;
  logic [NW_W-1:0]   cnt_d;
  logic              done_q;

  // Out-of-range or zero word counts mean "whole block".
  assign cnt_d = ((nwords == '0) || (nwords > NFULL)) ? NFULL : nwords;

  // Next buffer contents after one word leaves from the top.
  assign bfr_d = {bfr_q[BW-WORD_W-1:0], {WORD_W{1'b0}}};

  // Two-state control, shift register and word counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      bfr_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (ld) begin
            bfr_q   <= din;
            cnt_q   <= cnt_d;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (pdo_ready) begin
            bfr_q <= bfr_d;
            cnt_q <= cnt_q - ONE;
            if (cnt_q == ONE) begin
              state_q <= IDLE;
              done_q  <= 1'b1;
`ifdef PDO_PARSER_ZEROIZE_EN
              bfr_q   <= '0;
`endif
            end
          end
        end
      endcase
    end
  end

  assign pdo       = bfr_q[BW-1 -: WORD_W];
  assign busy      = (state_q == BUSY);
  assign pdo_valid = busy;
  assign pdo_last  = busy && (cnt_q == ONE);
  assign done      = done_q;

endmodule

// File: tb/tb_pdo_parser.sv
// Bench for pdo_parser: word-queue reference model checked every cycle,
// directed scenarios with literal expectations, then random traffic.
module tb_pdo_parser;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] din;
  logic [2:0]   nwords;
  logic         ld;
  logic [31:0]  pdo;
  logic         pdo_valid;
  logic         pdo_ready;
  logic         pdo_last;
  logic         busy;
  logic         done;

  logic [255:0] din2;
  logic [3:0]   nwords2;
  logic         ld2;
  logic [31:0]  pdo2;
  logic         pdo_valid2;
  logic         pdo_ready2;
  logic         pdo_last2;
  logic         busy2;
  logic         done2;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [127:0] BLK = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  logic [31:0] wexp [4];

  always #5 clk = ~clk;

  pdo_parser #(.KD(1)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din),
    .nwords    (nwords),
    .ld        (ld),
    .pdo       (pdo),
    .pdo_valid (pdo_valid),
    .pdo_ready (pdo_ready),
    .pdo_last  (pdo_last),
    .busy      (busy),
    .done      (done)
  );

  pdo_parser #(.KD(2)) u_dut2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din2),
    .nwords    (nwords2),
    .ld        (ld2),
    .pdo       (pdo2),
    .pdo_valid (pdo_valid2),
    .pdo_ready (pdo_ready2),
    .pdo_last  (pdo_last2),
    .busy      (busy2),
    .done      (done2)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: the loaded block as a list of words plus a read index.
  logic        m_init = 1'b0;
  logic        m_busy;
  logic        m_done;
  logic [31:0] m_idle;
  logic [31:0] m_words [4];
  int          m_idx;
  int          m_n;

  always @(negedge clk) begin
    if (m_init) begin
      chk("m_busy",  {31'd0, busy},      {31'd0, m_busy});
      chk("m_valid", {31'd0, pdo_valid}, {31'd0, m_busy});
      chk("m_last",  {31'd0, pdo_last},
          {31'd0, m_busy && (m_n - m_idx == 1)});
      chk("m_done",  {31'd0, done},      {31'd0, m_done});
      chk("m_pdo",   pdo, m_busy ? m_words[m_idx] : m_idle);
    end
    if (!rst_n) begin
      m_init = 1'b1;
      m_busy = 1'b0;
      m_done = 1'b0;
      m_idle = 32'h0;
      m_idx  = 0;
      m_n    = 0;
    end else if (m_init) begin
      m_done = 1'b0;
      if (m_busy) begin
        if (pdo_ready) begin
          m_idx++;
          if (m_idx == m_n) begin
            m_busy = 1'b0;
            m_done = 1'b1;
`ifdef PDO_PARSER_ZEROIZE_EN
            m_idle = 32'h0;
`else
            m_idle = (m_idx < 4) ? m_words[m_idx] : 32'h0;
`endif
          end
        end
      end else if (ld) begin
        for (int i = 0; i < 4; i++) m_words[i] = din[127-32*i -: 32];
        m_n    = (nwords == 0 || nwords > 4) ? 4 : int'(nwords);
        m_idx  = 0;
        m_busy = 1'b1;
      end
    end
  end

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [127:0] d, input logic [2:0] n);
    din    = d;
    nwords = n;
    ld     = 1'b1;
    cyc;
    ld     = 1'b0;
  endtask

  logic [31:0] idle_exp;

  initial begin
    wexp[0] = 32'h00112233;
    wexp[1] = 32'h44556677;
    wexp[2] = 32'h8899AABB;
    wexp[3] = 32'hCCDDEEFF;
`ifdef PDO_PARSER_ZEROIZE_EN
    idle_exp = 32'h0;
`else
    idle_exp = 32'h8899AABB;
`endif
    rst_n = 1'b0; ld = 1'b0; din = '0; nwords = '0; pdo_ready = 1'b0;
    ld2 = 1'b0; din2 = '0; nwords2 = '0; pdo_ready2 = 1'b1;
    repeat (3) cyc;
    chk("rst_pdo",   pdo, 32'h0);
    chk("rst_valid", {31'd0, pdo_valid}, 32'd0);
    chk("rst_busy",  {31'd0, busy}, 32'd0);
    chk("rst_last",  {31'd0, pdo_last}, 32'd0);
    chk("rst_done",  {31'd0, done}, 32'd0);
    rst_n = 1'b1;
    cyc;

    // Full block, no stalls.
    pdo_ready = 1'b1;
    load(BLK, 3'd0);
    for (int i = 0; i < 4; i++) begin
      chk("full_pdo", pdo, wexp[i]);
      chk("full_last", {31'd0, pdo_last}, {31'd0, i == 3});
      cyc;
    end
    chk("full_done", {31'd0, done}, 32'd1);
    chk("full_busy", {31'd0, busy}, 32'd0);
    cyc;
    chk("full_done_off", {31'd0, done}, 32'd0);

    // Backpressure after the first transfer.
    load(BLK, 3'd0);
    chk("bp_w0", pdo, wexp[0]);
    cyc;
    pdo_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc;
      chk("bp_hold", pdo, wexp[1]);
      chk("bp_valid", {31'd0, pdo_valid}, 32'd1);
      chk("bp_last", {31'd0, pdo_last}, 32'd0);
    end
    pdo_ready = 1'b1;
    cyc;
    chk("bp_w2", pdo, wexp[2]);
    cyc;
    chk("bp_w3", pdo, wexp[3]);
    cyc;
    chk("bp_done", {31'd0, done}, 32'd1);

    // Partial block of two words.
    load(BLK, 3'd2);
    chk("part_w0", pdo, wexp[0]);
    chk("part_last0", {31'd0, pdo_last}, 32'd0);
    cyc;
    chk("part_w1", pdo, wexp[1]);
    chk("part_last1", {31'd0, pdo_last}, 32'd1);
    cyc;
    chk("part_done", {31'd0, done}, 32'd1);
    chk("part_idle", pdo, idle_exp);
    cyc;
    chk("part_idle2", pdo, idle_exp);
    chk("part_valid", {31'd0, pdo_valid}, 32'd0);

    // Oversized count clamps to the full block.
    load(BLK, 3'd7);
    for (int i = 0; i < 4; i++) begin
      chk("n7_pdo", pdo, wexp[i]);
      chk("n7_last", {31'd0, pdo_last}, {31'd0, i == 3});
      cyc;
    end
    chk("n7_done", {31'd0, done}, 32'd1);

    // Loads during BUSY, including on the final transfer, are ignored.
    load(BLK, 3'd0);
    ld  = 1'b1;
    din = '1;
    for (int i = 0; i < 4; i++) begin
      chk("ign_pdo", pdo, wexp[i]);
      cyc;
    end
    ld = 1'b0;
    chk("ign_busy", {31'd0, busy}, 32'd0);
    chk("ign_done", {31'd0, done}, 32'd1);
    cyc;
    chk("ign_busy2", {31'd0, busy}, 32'd0);

    // Reset after two transfers.
    load(BLK, 3'd0);
    cyc;
    cyc;
    chk("rm_w2", pdo, wexp[2]);
    rst_n = 1'b0;
    cyc;
    chk("rm_valid", {31'd0, pdo_valid}, 32'd0);
    chk("rm_busy", {31'd0, busy}, 32'd0);
    chk("rm_pdo", pdo, 32'h0);
    chk("rm_done", {31'd0, done}, 32'd0);
    rst_n = 1'b1;
    cyc;
    chk("rm_done2", {31'd0, done}, 32'd0);
    load(BLK, 3'd0);
    chk("rm_restart", pdo, wexp[0]);
    repeat (5) cyc;

    // KD=2 instance: word i carries value i.
    for (int i = 0; i < 8; i++) din2[255-32*i -: 32] = i;
    nwords2 = '0;
    ld2 = 1'b1;
    cyc;
    ld2 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("kd2_pdo", pdo2, i);
      chk("kd2_last", {31'd0, pdo_last2}, {31'd0, i == 7});
      cyc;
    end
    chk("kd2_done", {31'd0, done2}, 32'd1);
    cyc;
    chk("kd2_done_off", {31'd0, done2}, 32'd0);

    // Random traffic against the model.
    repeat (3000) begin
      ld        = ($urandom_range(0, 3) == 0);
      din       = {$urandom, $urandom, $urandom, $urandom};
      nwords    = 3'($urandom_range(0, 7));
      pdo_ready = ($urandom_range(0, 3) != 0);
      rst_n     = ($urandom_range(0, 199) != 0);
      cyc;
    end
    rst_n = 1'b1;
    ld = 1'b0;
    pdo_ready = 1'b1;
    repeat (10) cyc;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
